// File: rtl/data_mem_if.sv
// M-stage data port bundle: CPU address/data/byte-enable in, read data out,
// plus the write-trace valid/ready stream drained by a monitor.
interface data_mem_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        addr_err;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    output m_inst_addr,
    output trace_ready,
    input  m_data_rdata,
    input  addr_err,
    input  trace_valid,
    input  trace_pc,
    input  trace_addr,
    input  trace_data,
    input  trace_overflow
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    input  m_inst_addr,
    input  trace_ready,
    output m_data_rdata,
    output addr_err,
    output trace_valid,
    output trace_pc,
    output trace_addr,
    output trace_data,
    output trace_overflow
  );
endinterface

// File: rtl/data_mem_slave.sv
// Data memory for the M stage: combinational read, byte-enabled write on
// the clock edge, and a small FIFO tracing every committed write.
// Ports: clk, reset (sync, active-high), bus (data_mem_if.slave).
module data_mem_slave #(
  parameter int DEPTH       = 3072,
  parameter int TRACE_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TRACE_DEPTH);

  logic [31:0] mem_q [DEPTH];

  logic [29:0]   idx;
  logic [AW-1:0] widx;
  logic          in_range;
  logic          wr_en;
  logic [31:0]   old_word;
  logic [31:0]   merged;

  assign idx      = bus.m_data_addr[31:2];
  assign widx     = idx[AW-1:0];
  assign in_range = (32'(idx) < 32'(DEPTH));
  assign wr_en    = in_range && (bus.m_data_byteen != 4'b0000);
  assign old_word = in_range ? mem_q[widx] : 32'h0;

  assign bus.m_data_rdata = old_word;

  always_comb begin
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (bus.m_data_byteen[k]) merged[8*k +: 8] = bus.m_data_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[widx] <= merged;
    end
  end

  logic [31:0] f_pc_q   [TRACE_DEPTH];
  logic [31:0] f_addr_q [TRACE_DEPTH];
  logic [31:0] f_data_q [TRACE_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          pop, full, wr_slot;

  assign pop  = (cnt_q != '0) && bus.trace_ready;
  assign full = (cnt_q == (PW+1)'(TRACE_DEPTH));

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    err_d    = !in_range;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_slot  = wr_en && (pop || !full);
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_slot) wr_ptr_d = wr_ptr_q + 1'b1;
    if (wr_en && !wr_slot) ovf_d = 1'b1;
    unique case (1'b1)
      (wr_slot && !pop): cnt_d = cnt_q + 1'b1;
      (pop && !wr_slot): cnt_d = cnt_q - 1'b1;
      default:           cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Entries are qualified by cnt_q, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_slot) begin
      f_pc_q[wr_ptr_q]   <= bus.m_inst_addr;
      f_addr_q[wr_ptr_q] <= {idx, 2'b00};
      f_data_q[wr_ptr_q] <= merged;
    end
  end

  assign bus.trace_valid    = (cnt_q != '0);
  assign bus.trace_pc       = bus.trace_valid ? f_pc_q[rd_ptr_q]   : 32'h0;
  assign bus.trace_addr     = bus.trace_valid ? f_addr_q[rd_ptr_q] : 32'h0;
  assign bus.trace_data     = bus.trace_valid ? f_data_q[rd_ptr_q] : 32'h0;
  assign bus.trace_overflow = ovf_q;
  assign bus.addr_err       = err_q;
endmodule

// File: tb/tb_data_mem_slave.sv
// Bench for data_mem_slave: reference memory/queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_data_mem_slave;
  localparam int DEPTH = 3072;
  localparam int TD    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  data_mem_if bus ();

  data_mem_slave #(.DEPTH(DEPTH), .TRACE_DEPTH(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic [31:0] mm [DEPTH];
  rec_t        q [$];
  bit          m_ovf = 1'b0;
  bit          m_err = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain word array and a record queue.
  always @(posedge clk) begin : mdl
    int unsigned wi;
    bit          inr;
    logic [31:0] w;
    rec_t        r;
    if (reset) begin
      foreach (mm[i]) mm[i] = 32'h0;
      q.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
    end else begin
      wi  = bus.m_data_addr >> 2;
      inr = (wi < DEPTH);
      if (q.size() != 0 && bus.trace_ready) void'(q.pop_front());
      if (inr && bus.m_data_byteen != 4'b0) begin
        w = mm[wi];
        for (int k = 0; k < 4; k++)
          if (bus.m_data_byteen[k]) w[8*k +: 8] = bus.m_data_wdata[8*k +: 8];
        mm[wi] = w;
        r.pc = bus.m_inst_addr;
        r.addr = wi * 4;
        r.data = w;
        if (q.size() < TD) q.push_back(r);
        else m_ovf = 1'b1;
      end
      m_err = !inr;
    end
  end

  always @(negedge clk) begin : cmp
    int unsigned wi;
    if (chk_en) begin
      wi = bus.m_data_addr >> 2;
      check("rdata", bus.m_data_rdata, (wi < DEPTH) ? mm[wi] : 32'h0);
      check("valid", 32'(bus.trace_valid), 32'(q.size() != 0));
      check("ovf", 32'(bus.trace_overflow), 32'(m_ovf));
      check("err", 32'(bus.addr_err), 32'(m_err));
      if (q.size() != 0) begin
        check("t_pc", bus.trace_pc, q[0].pc);
        check("t_addr", bus.trace_addr, q[0].addr);
        check("t_data", bus.trace_data, q[0].data);
      end else begin
        check("t_pc0", bus.trace_pc, 32'h0);
        check("t_addr0", bus.trace_addr, 32'h0);
        check("t_data0", bus.trace_data, 32'h0);
      end
    end
  end

  // One cycle: apply inputs after the edge, return at the following negedge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] w,
                     input logic [3:0] be, input logic [31:0] pc,
                     input logic rdy);
    @(posedge clk);
    #1;
    bus.m_data_addr   = a;
    bus.m_data_wdata  = w;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    bus.trace_ready   = rdy;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.m_data_addr   = 32'h0;
    bus.m_data_wdata  = 32'h0;
    bus.m_data_byteen = 4'h0;
    bus.m_inst_addr   = 32'h0;
    bus.trace_ready   = 1'b0;

    // 1: reset state
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    cyc(32'h0, 0, 0, 0, 0);
    check("rst_rdata", bus.m_data_rdata, 32'h0);
    check("rst_valid", 32'(bus.trace_valid), 32'h0);
    check("rst_err", 32'(bus.addr_err), 32'h0);
    check("rst_ovf", 32'(bus.trace_overflow), 32'h0);
    cyc(32'h2FFC, 0, 0, 0, 0);
    check("top_rdata", bus.m_data_rdata, 32'h0);
    cyc(32'h0, 0, 0, 0, 0);
    check("top_err", 32'(bus.addr_err), 32'h0);

    // 2: full-word store
    cyc(32'h10, 32'h12345678, 4'b1111, 32'h3000, 0);
    check("sw_prewrite", bus.m_data_rdata, 32'h0);
    cyc(32'h10, 0, 0, 0, 0);
    check("sw_rdata", bus.m_data_rdata, 32'h12345678);
    check("sw_tpc", bus.trace_pc, 32'h3000);
    check("sw_taddr", bus.trace_addr, 32'h10);
    check("sw_tdata", bus.trace_data, 32'h12345678);

    // 3: byte and halfword merges
    cyc(32'h12, 32'hABABABAB, 4'b0100, 32'h3004, 0);
    cyc(32'h10, 0, 0, 0, 0);
    check("sb_rdata", bus.m_data_rdata, 32'h12AB5678);
    cyc(32'h10, 32'hCDEFCDEF, 4'b0011, 32'h3008, 0);
    cyc(32'h10, 0, 0, 0, 0);
    check("sh_rdata", bus.m_data_rdata, 32'h12ABCDEF);
    cyc(0, 0, 0, 0, 1);
    check("drain0", bus.trace_data, 32'h12345678);
    cyc(0, 0, 0, 0, 1);
    check("drain1", bus.trace_data, 32'h12AB5678);
    check("drain1_addr", bus.trace_addr, 32'h10);
    cyc(0, 0, 0, 0, 1);
    check("drain2", bus.trace_data, 32'h12ABCDEF);
    cyc(0, 0, 0, 0, 0);
    check("drained", 32'(bus.trace_valid), 32'h0);

    // 4: overflow with no draining
    for (int i = 0; i < 5; i++)
      cyc(32'h100 + 4*i, 32'hA0000000 + i, 4'b1111, 32'h3000 + 4*i, 0);
    cyc(32'h100, 0, 0, 0, 0);
    check("ovf_set", 32'(bus.trace_overflow), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(32'h100 + 4*i, 0, 0, 0, 0);
      check("ovf_mem", bus.m_data_rdata, 32'hA0000000 + i);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("ovf_drain_pc", bus.trace_pc, 32'h3000 + 4*i);
    end
    cyc(0, 0, 0, 0, 0);
    check("ovf_empty", 32'(bus.trace_valid), 32'h0);
    check("ovf_sticky", 32'(bus.trace_overflow), 32'h1);

    // 5: push and pop together while full
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc(32'h200 + 4*i, 32'hB0 + i, 4'b1111, 32'h4000 + 4*i, 0);
    cyc(32'h210, 32'hB4, 4'b1111, 32'h4010, 1);
    cyc(0, 0, 0, 0, 0);
    check("pp_ovf", 32'(bus.trace_overflow), 32'h0);
    check("pp_head", bus.trace_pc, 32'h4004);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("pp_drain_pc", bus.trace_pc, 32'h4000 + 4*i);
    end
    cyc(0, 0, 0, 0, 0);
    check("pp_empty", 32'(bus.trace_valid), 32'h0);
    check("pp_ovf_end", 32'(bus.trace_overflow), 32'h0);

    // 6: out-of-range access, then reset with records pending
    cyc(32'h3000, 32'hDEADBEEF, 4'b1111, 32'h5000, 0);
    check("oor_rdata", bus.m_data_rdata, 32'h0);
    cyc(32'h3000, 0, 0, 0, 0);
    check("oor_err_w", 32'(bus.addr_err), 32'h1);
    check("oor_rd", bus.m_data_rdata, 32'h0);
    check("oor_nopush", 32'(bus.trace_valid), 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("oor_err_r", 32'(bus.addr_err), 32'h1);
    cyc(0, 0, 0, 0, 0);
    check("oor_err_clr", 32'(bus.addr_err), 32'h0);
    cyc(32'h10, 32'h11111111, 4'b1111, 32'h6000, 0);
    cyc(32'h14, 32'h22222222, 4'b1111, 32'h6004, 0);
    cyc(32'h18, 32'h33333333, 4'b1111, 32'h6008, 0);
    check("pend_valid", 32'(bus.trace_valid), 32'h1);
    reset = 1'b1;
    cyc(32'h10, 0, 0, 0, 0);
    check("rst_mid_valid", 32'(bus.trace_valid), 32'h0);
    check("rst_mid_mem4", bus.m_data_rdata, 32'h0);
    reset = 1'b0;
    cyc(32'h18, 0, 0, 0, 0);
    check("rst_drop_wr", bus.m_data_rdata, 32'h0);
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
